// File: rtl/platform_seg7_scan.sv
// Time-multiplexed seven-segment scanner with a per-frame shadow of the digit patterns.
// Optional inter-digit blanking is compiled in with `define SEG7_SCAN_BLANK_EN.
module platform_seg7_scan #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned PRESCALE     = 50000,
   parameter int unsigned BLANK_CYCLES = 500,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic [7*NUM_DIGITS-1:0] digits_in,
   output logic [6:0]              seg_out,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    frame_tick
);

   localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [6:0]            SegOff = {7{ACTIVE_LOW}};
   localparam logic [NUM_DIGITS-1:0] DigOff = {NUM_DIGITS{ACTIVE_LOW}};

   typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

`ifdef SEG7_SCAN_BLANK_EN
   localparam state_e SlotStart = StBlank;
`else
   localparam state_e SlotStart = StDrive;
   logic w_unused_cfg;
   assign w_unused_cfg = (BLANK_CYCLES == 0);
`endif

   state_e                  r_state, w_state;
   logic [IdxW-1:0]         r_idx, w_idx;
   logic [CntW-1:0]         r_cnt, w_cnt;
   logic [7*NUM_DIGITS-1:0] r_shadow, w_shadow;
   logic [6:0]              r_seg, w_seg;
   logic [NUM_DIGITS-1:0]   r_dig, w_dig;
   logic                    r_tick, w_tick;
   logic [6:0]              w_pat;
   logic                    w_slot_end, w_last;

   assign w_slot_end = (r_cnt == CntW'(PRESCALE - 1));
   assign w_last     = (r_idx == IdxW'(NUM_DIGITS - 1));

   always_comb begin
      w_state  = r_state;
      w_idx    = r_idx;
      w_cnt    = r_cnt;
      w_shadow = r_shadow;
      w_tick   = 1'b0;
      if (!enable) begin
         w_state = StIdle;
         w_idx   = '0;
         w_cnt   = '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               w_state  = SlotStart;
               w_idx    = '0;
               w_cnt    = '0;
               w_shadow = digits_in;
               w_tick   = 1'b1;
            end
`ifdef SEG7_SCAN_BLANK_EN
            StBlank: begin
               w_cnt = r_cnt + CntW'(1);
               if (r_cnt == CntW'(BLANK_CYCLES - 1)) w_state = StDrive;
            end
`endif
            StDrive: begin
               if (w_slot_end) begin
                  w_state = SlotStart;
                  w_cnt   = '0;
                  if (w_last) begin
                     // Frame wrap: fresh snapshot so a frame never mixes old and new patterns.
                     w_idx    = '0;
                     w_shadow = digits_in;
                     w_tick   = 1'b1;
                  end else begin
                     w_idx = r_idx + IdxW'(1);
                  end
               end else begin
                  w_cnt = r_cnt + CntW'(1);
               end
            end
            default: begin
               w_state = StIdle;
               w_idx   = '0;
               w_cnt   = '0;
            end
         endcase
      end
   end

   // Outputs are derived from next-state values so they register on the same edge.
   always_comb begin
      w_pat = '0;
      w_seg = SegOff;
      w_dig = DigOff;
      if (w_state == StDrive) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx == IdxW'(i)) begin
               w_pat    = w_shadow[7*i +: 7];
               w_dig[i] = ~ACTIVE_LOW;
            end
         end
         w_seg = ACTIVE_LOW ? ~w_pat : w_pat;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= StIdle;
         r_idx    <= '0;
         r_cnt    <= '0;
         r_shadow <= '0;
         r_seg    <= SegOff;
         r_dig    <= DigOff;
         r_tick   <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_idx    <= w_idx;
         r_cnt    <= w_cnt;
         r_shadow <= w_shadow;
         r_seg    <= w_seg;
         r_dig    <= w_dig;
         r_tick   <= w_tick;
      end
   end

   assign seg_out    = r_seg;
   assign dig_sel    = r_dig;
   assign frame_tick = r_tick;

endmodule
